// File: rtl/can_tx_frame_loader.sv
// can_tx_frame_loader
//
// Pops one 128-bit word from the CAN TX FIFO, unpacks it into CAN frame
// fields and offers the frame to the CAN TX bit engine. The frame is held
// until the engine reports completion. Bus errors cause up to MAX_RETRY
// retransmissions, after which the frame is dropped.
//
// Ports
//   i_sys_clk, i_reset        clock, synchronous active-high reset
//   i_fifo_empty              FIFO empty flag
//   i_fifo_underflow          FIFO underflow flag (valid in the cycle after a pop)
//   i_fifo_r_data             FIFO read data
//   o_fifo_r_en               one-cycle pop pulse
//   o_frame_valid/i_frame_ready  frame offer handshake to the TX engine
//   o_frame_id/ide/rtr/dlc/data  unpacked frame fields
//   o_data_bits               payload bit count (0 for remote frames)
//   i_tx_done, i_tx_err       completion / failure pulses from the engine
//   i_abort                   host abort of the current frame
//   o_sent, o_drop            one-cycle completion / discard pulses
//   o_busy                    high whenever the loader is not idle
//   o_retry_cnt               retries used on the current frame
//   o_drop_cnt                saturating dropped-frame counter
//   o_state                   current FSM state (debug)
//
// Handshake: the frame transfers on the rising edge where o_frame_valid and
// i_frame_ready are both high. Once raised, o_frame_valid stays high with
// stable fields until that transfer, unless i_abort or i_reset intervenes.

module can_tx_frame_loader #(
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_underflow,
  input  logic [DATA_WIDTH-1:0] i_fifo_r_data,
  output logic                  o_fifo_r_en,
  output logic                  o_frame_valid,
  input  logic                  i_frame_ready,
  output logic [28:0]           o_frame_id,
  output logic                  o_frame_ide,
  output logic                  o_frame_rtr,
  output logic [3:0]            o_frame_dlc,
  output logic [63:0]           o_frame_data,
  output logic [6:0]            o_data_bits,
  input  logic                  i_tx_done,
  input  logic                  i_tx_err,
  input  logic                  i_abort,
  output logic                  o_sent,
  output logic                  o_drop,
  output logic                  o_busy,
  output logic [3:0]            o_retry_cnt,
  output logic [7:0]            o_drop_cnt,
  output logic [2:0]            o_state
);

  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_OFFER = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   load_fields;
  logic   retry_inc;

  // Reserved word bits carry no meaning for the loader.
  logic unused_rsvd;
  assign unused_rsvd = ^i_fifo_r_data[96:68];

  // Field decode of the word currently on the FIFO read port.
  logic [3:0] w_dlc;
  logic [6:0] w_data_bits;
  assign w_dlc       = i_fifo_r_data[67:64];
  assign w_data_bits = i_fifo_r_data[126]  ? 7'd0 :
                       (w_dlc > 4'd8)      ? 7'd64 :
                                             {w_dlc, 3'b000};

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    o_fifo_r_en   = 1'b0;
    o_frame_valid = 1'b0;
    o_sent        = 1'b0;
    o_drop        = 1'b0;
    load_fields   = 1'b0;
    retry_inc     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!i_fifo_empty) state_nxt = S_READ;
      end
      S_READ: begin
        o_fifo_r_en = 1'b1;
        state_nxt   = S_LATCH;
      end
      S_LATCH: begin
        // An underflowed pop carries no frame; it is silently discarded.
        if (i_fifo_underflow) begin
          state_nxt = S_IDLE;
        end else begin
          load_fields = 1'b1;
          state_nxt   = S_OFFER;
        end
      end
      S_OFFER: begin
        o_frame_valid = 1'b1;
        if (i_abort) begin
          o_drop    = 1'b1;
          state_nxt = S_IDLE;
        end else if (i_frame_ready) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Priority: abort, then done, then error.
        if (i_abort) begin
          o_drop    = 1'b1;
          state_nxt = S_IDLE;
        end else if (i_tx_done) begin
          o_sent    = 1'b1;
          state_nxt = S_IDLE;
        end else if (i_tx_err) begin
          if (o_retry_cnt < MAX_RETRY_C) begin
            retry_inc = 1'b1;
            state_nxt = S_OFFER;
          end else begin
            o_drop    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

  // Frame fields: loaded once per pop, held through retries and in IDLE.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      o_frame_id   <= '0;
      o_frame_ide  <= 1'b0;
      o_frame_rtr  <= 1'b0;
      o_frame_dlc  <= '0;
      o_frame_data <= '0;
      o_data_bits  <= '0;
    end else if (load_fields) begin
      o_frame_ide  <= i_fifo_r_data[127];
      o_frame_rtr  <= i_fifo_r_data[126];
      o_frame_id   <= i_fifo_r_data[127] ? i_fifo_r_data[125:97]
                                         : {18'd0, i_fifo_r_data[125:115]};
      o_frame_dlc  <= w_dlc;
      o_frame_data <= i_fifo_r_data[63:0];
      o_data_bits  <= w_data_bits;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      o_retry_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      if (load_fields)    o_retry_cnt <= '0;
      else if (retry_inc) o_retry_cnt <= o_retry_cnt + 4'd1;
      if (o_drop && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_can_tx_frame_loader.sv
module tb_can_tx_frame_loader;

  localparam int MAX_RETRY = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         fifo_empty, fifo_underflow;
  logic [127:0] fifo_r_data;
  logic         fifo_r_en, frame_valid, frame_ready;
  logic [28:0]  frame_id;
  logic         frame_ide, frame_rtr;
  logic [3:0]   frame_dlc;
  logic [63:0]  frame_data;
  logic [6:0]   data_bits;
  logic         tx_done, tx_err, tx_abort;
  logic         sent, drop, busy;
  logic [3:0]   retry_cnt;
  logic [7:0]   drop_cnt;
  logic [2:0]   dbg_state;

  can_tx_frame_loader #(.MAX_RETRY(MAX_RETRY), .DATA_WIDTH(128)) dut (
    .i_sys_clk        (clk),
    .i_reset          (reset),
    .i_fifo_empty     (fifo_empty),
    .i_fifo_underflow (fifo_underflow),
    .i_fifo_r_data    (fifo_r_data),
    .o_fifo_r_en      (fifo_r_en),
    .o_frame_valid    (frame_valid),
    .i_frame_ready    (frame_ready),
    .o_frame_id       (frame_id),
    .o_frame_ide      (frame_ide),
    .o_frame_rtr      (frame_rtr),
    .o_frame_dlc      (frame_dlc),
    .o_frame_data     (frame_data),
    .o_data_bits      (data_bits),
    .i_tx_done        (tx_done),
    .i_tx_err         (tx_err),
    .i_abort          (tx_abort),
    .o_sent           (sent),
    .o_drop           (drop),
    .o_busy           (busy),
    .o_retry_cnt      (retry_cnt),
    .o_drop_cnt       (drop_cnt),
    .o_state          (dbg_state)
  );

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [6:0]  bits;
  } frame_t;

  logic [127:0] fifo_q[$];   // words sitting in the emulated FIFO
  frame_t       exp_q[$];    // expected frames, in pop order
  bit           fake_ne = 1'b0;
  int           n_vec = 0, n_err = 0, pop_cnt = 0;
  int           exp_drops = 0, exp_retry = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_fields(input string tag);
    frame_t f;
    if (exp_q.size() == 0) begin
      chk({tag, "_expq_empty"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    f = exp_q[0];
    chk({tag, "_id"},   64'(frame_id),   64'(f.id));
    chk({tag, "_ide"},  64'(frame_ide),  64'(f.ide));
    chk({tag, "_rtr"},  64'(frame_rtr),  64'(f.rtr));
    chk({tag, "_dlc"},  64'(frame_dlc),  64'(f.dlc));
    chk({tag, "_data"}, frame_data,      f.data);
    chk({tag, "_bits"}, 64'(data_bits),  64'(f.bits));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ren"},   64'(fifo_r_en),   0);
    chk({tag, "_valid"}, 64'(frame_valid), 0);
    chk({tag, "_id"},    64'(frame_id),    0);
    chk({tag, "_ide"},   64'(frame_ide),   0);
    chk({tag, "_rtr"},   64'(frame_rtr),   0);
    chk({tag, "_dlc"},   64'(frame_dlc),   0);
    chk({tag, "_data"},  frame_data,       0);
    chk({tag, "_bits"},  64'(data_bits),   0);
    chk({tag, "_sent"},  64'(sent),        0);
    chk({tag, "_drop"},  64'(drop),        0);
    chk({tag, "_busy"},  64'(busy),        0);
    chk({tag, "_retry"}, 64'(retry_cnt),   0);
    chk({tag, "_dcnt"},  64'(drop_cnt),    0);
  endtask

  // ---------------- driver tasks ----------------
  // One clock; afterwards the emulated FIFO reacts to a pop seen on that edge.
  task automatic tick();
    logic ren;
    ren = fifo_r_en;
    @(posedge clk);
    #1;
    fifo_underflow = 1'b0;
    if (ren) begin
      pop_cnt++;
      if (fifo_q.size() > 0) fifo_r_data = fifo_q.pop_front();
      else                   fifo_underflow = 1'b1;
    end
    fifo_empty = (fifo_q.size() == 0) && !fake_ne;
  endtask

  // Build a FIFO word with junk in every ignored bit, and the frame the
  // engine should see, straight from the field values.
  task automatic push_frame(input logic ide, input logic rtr, input logic [28:0] id,
                            input logic [3:0] dlc, input logic [63:0] data);
    logic [127:0] w;
    frame_t       f;
    int           nbytes;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[127]     = ide;
    w[126]     = rtr;
    if (ide) w[125:97]  = id;
    else     w[125:115] = id[10:0];
    w[67:64]   = dlc;
    w[63:0]    = data;
    nbytes     = (int'(dlc) < 8) ? int'(dlc) : 8;
    f.id   = ide ? id : {18'd0, id[10:0]};
    f.ide  = ide;
    f.rtr  = rtr;
    f.dlc  = dlc;
    f.data = data;
    f.bits = rtr ? 7'd0 : 7'(nbytes * 8);
    fifo_q.push_back(w);
    exp_q.push_back(f);
    fifo_empty = 1'b0;
  endtask

  // Called in the IDLE cycle where the FIFO is non-empty (cycle 0).
  task automatic load_frame(input bit abort_early);
    int p0;
    p0 = pop_cnt;
    if (abort_early) tx_abort = 1'b1;
    tick(); #1;
    chk("ren_c1", 64'(fifo_r_en), 1);
    chk("valid_c1", 64'(frame_valid), 0);
    tick(); #1;
    chk("ren_c2", 64'(fifo_r_en), 0);
    chk("valid_c2", 64'(frame_valid), 0);
    tx_abort = 1'b0;
    tick(); #1;
    chk("valid_c3", 64'(frame_valid), 1);
    chk("pops_per_load", 64'(pop_cnt - p0), 1);
    chk("retry_after_load", 64'(retry_cnt), 0);
    chk_fields("load");
    exp_retry = 0;
  endtask

  // Hold ready low for bp cycles, then transfer.
  task automatic accept(input int bp);
    for (int i = 0; i < bp; i++) begin
      frame_ready = 1'b0;
      tx_done = (i == 0);   // done outside BUSY must be ignored
      #1;
      chk("sent_in_offer", 64'(sent), 0);
      tick();
      tx_done = 1'b0;
      #1;
      chk("valid_hold", 64'(frame_valid), 1);
      chk("hold_id", 64'(frame_id), 64'(exp_q[0].id));
      chk("hold_data", frame_data, exp_q[0].data);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    #1;
    chk("valid_after_xfer", 64'(frame_valid), 0);
    chk("busy_after_xfer", 64'(busy), 1);
  endtask

  task automatic busy_step(input bit d, input bit e, input bit a,
                           output bit finished, output bit retried);
    bit exp_sent, exp_drop;
    exp_sent = 0; exp_drop = 0; finished = 0; retried = 0;
    tx_done = d; tx_err = e; tx_abort = a;
    #1;
    if (a)                         begin exp_drop = 1; finished = 1; end
    else if (d)                    begin exp_sent = 1; finished = 1; end
    else if (e && exp_retry < MAX_RETRY) retried = 1;
    else if (e)                    begin exp_drop = 1; finished = 1; end
    chk("sent", 64'(sent), 64'(exp_sent));
    chk("drop", 64'(drop), 64'(exp_drop));
    tick();
    tx_done = 0; tx_err = 0; tx_abort = 0;
    #1;
    if (exp_drop) exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
    if (retried) begin
      exp_retry++;
      chk("valid_retry", 64'(frame_valid), 1);
      chk("retry_cnt", 64'(retry_cnt), 64'(exp_retry));
      chk_fields("retry");
    end else if (finished) begin
      chk("idle_after_end", 64'(busy), 0);
      chk("sent_one_cycle", 64'(sent), 0);
      chk("drop_one_cycle", 64'(drop), 0);
      void'(exp_q.pop_front());
    end else begin
      chk("still_busy", 64'(busy), 1);
      chk("valid_in_busy", 64'(frame_valid), 0);
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
  endtask

  task automatic abort_offer();
    tx_abort = 1'b1;
    #1;
    chk("abort_offer_drop", 64'(drop), 1);
    chk("abort_offer_sent", 64'(sent), 0);
    tick();
    tx_abort = 1'b0;
    #1;
    exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
    chk("abort_offer_idle", 64'(busy), 0);
    chk("abort_offer_valid", 64'(frame_valid), 0);
    chk("abort_offer_dcnt", 64'(drop_cnt), 64'(exp_drops));
    void'(exp_q.pop_front());
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit fin, ret;
    int p0, steps;
    reset = 1; fifo_empty = 1; fifo_underflow = 0; fifo_r_data = '0;
    frame_ready = 0; tx_done = 0; tx_err = 0; tx_abort = 0;

    // Reset state
    tick(); tick(); #1;
    chk_all_zero("reset");
    reset = 0;
    tick(); #1;

    // Single frame, with abort held during the IDLE/READ/LATCH cycles
    push_frame(0, 0, 29'h123, 4'd8, 64'h0123456789ABCDEF);
    load_frame(1);
    chk("single_id", 64'(frame_id), 64'h123);
    chk("single_bits", 64'(data_bits), 64);
    accept(0);
    busy_step(1, 0, 0, fin, ret);

    // DLC above 8, remote frame, extended ID
    push_frame(0, 0, 29'h7FF, 4'd12, 64'hA5A5_0000_FFFF_1234);
    load_frame(0);
    chk("dlc12_dlc", 64'(frame_dlc), 12);
    chk("dlc12_bits", 64'(data_bits), 64);
    accept(1);
    busy_step(1, 0, 0, fin, ret);
    push_frame(0, 1, 29'h055, 4'd4, 64'h1111_2222_3333_4444);
    load_frame(0);
    chk("rtr_bits", 64'(data_bits), 0);
    accept(0);
    busy_step(1, 0, 0, fin, ret);
    push_frame(1, 0, 29'h1ABCDEF0, 4'd3, 64'hDEAD_BEEF_0000_0001);
    load_frame(0);
    chk("ext_id", 64'(frame_id), 64'h1ABCDEF0);
    chk("ext_bits", 64'(data_bits), 24);
    accept(0);
    busy_step(1, 0, 0, fin, ret);

    // Retry exhaustion
    push_frame(0, 0, 29'h321, 4'd2, 64'h0);
    load_frame(0);
    p0 = pop_cnt;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      accept(0);
      busy_step(0, 1, 0, fin, ret);
    end
    chk("exhaust_dropcnt", 64'(drop_cnt), 1);
    tick(); tick(); #1;
    chk("exhaust_no_pop", 64'(pop_cnt - p0), 0);
    chk("exhaust_idle", 64'(busy), 0);

    // Backpressure for 10 cycles, then done+err together
    push_frame(1, 0, 29'h0F0F0F0F, 4'd15, 64'hCAFE_F00D_1234_5678);
    load_frame(0);
    accept(10);
    busy_step(1, 1, 0, fin, ret);

    // Abort in OFFER
    push_frame(0, 0, 29'h001, 4'd1, 64'hFF00_0000_0000_0000);
    load_frame(0);
    abort_offer();

    // Underflow in LATCH: FIFO claims non-empty but has nothing
    fake_ne = 1; fifo_empty = 0;
    tick();
    fake_ne = 0; fifo_empty = 1;
    #1;
    chk("uf_ren", 64'(fifo_r_en), 1);
    tick(); #1;
    chk("uf_flag", 64'(fifo_underflow), 1);
    chk("uf_valid_latch", 64'(frame_valid), 0);
    chk("uf_drop_latch", 64'(drop), 0);
    tick(); #1;
    chk("uf_idle", 64'(busy), 0);
    chk("uf_valid", 64'(frame_valid), 0);
    chk("uf_dcnt", 64'(drop_cnt), 64'(exp_drops));

    // Back-to-back: two frames queued, next pop two cycles after o_sent
    push_frame(0, 0, 29'h2AA, 4'd5, 64'h1);
    push_frame(1, 1, 29'h1000_0001, 4'd9, 64'h2);
    load_frame(0);
    accept(0);
    busy_step(1, 0, 0, fin, ret);
    load_frame(0);
    accept(0);
    busy_step(1, 0, 0, fin, ret);

    // Reset in BUSY, then a normal frame
    push_frame(0, 0, 29'h456, 4'd6, 64'h7);
    load_frame(0);
    accept(0);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk_all_zero("reset_busy");
    exp_drops = 0;
    exp_q.delete();
    push_frame(0, 0, 29'h456, 4'd6, 64'h7);
    load_frame(0);
    accept(0);
    busy_step(1, 0, 0, fin, ret);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      push_frame(1'($urandom), 1'($urandom_range(0, 3) == 0), 29'($urandom),
                 4'($urandom), {$urandom, $urandom});
      load_frame(1'($urandom));
      fin = 0;
      steps = 0;
      while (!fin) begin
        if ($urandom_range(0, 9) == 0) begin
          abort_offer();
          fin = 1;
        end else begin
          accept($urandom_range(0, 3));
          ret = 0;
          while (!fin && !ret) begin
            int k;
            k = $urandom_range(0, 9);
            steps++;
            if (steps > 12) k = 1;
            busy_step(k inside {[1:4]}, k inside {4, [5:7]}, k == 0, fin, ret);
          end
        end
      end
    end

    // Drop counter saturation
    for (int n = 0; n < 258; n++) begin
      push_frame(0, 0, 29'($urandom), 4'($urandom), {$urandom, $urandom});
      load_frame(0);
      abort_offer();
    end
    chk("drop_cnt_sat", 64'(drop_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
